// File: rtl/rnd_reader_if.sv
// Bundle between the random source / CPU side and rnd_reader.
// master drives the stream, bound and read request; slave answers with data and status.
interface rnd_reader_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    rnd_in;
  logic          bound_we;
  logic [7:0]    bound_in;
  logic          rd_req;
  logic [7:0]    rd_data;
  logic          rd_ack;
  logic          rd_err;
  logic [CW-1:0] count;
  logic          fault;

  modport master (
    output rnd_in, bound_we, bound_in, rd_req,
    input  rd_data, rd_ack, rd_err, count, fault
  );

  modport slave (
    input  rnd_in, bound_we, bound_in, rd_req,
    output rd_data, rd_ack, rd_err, count, fault
  );
endinterface

// File: rtl/rnd_reader.sv
// Random byte consumer: rejection sampling into a small FIFO, request/ack read port
// and a sticky stuck-source monitor.
module rnd_reader #(
  parameter int DEPTH       = 4,
  parameter int STUCK_LIMIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  rnd_reader_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [7:0]    LIMIT = 8'(STUCK_LIMIT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [7:0]    bound;
  logic [7:0]    prev;
  logic [7:0]    rep;
  logic [7:0]    rep_next;
  logic          prev_valid;
  logic          fault_r;
  logic          ack_r;
  logic          err_r;
  logic [7:0]    data_r;
  logic          serve;
  logic          pop;
  logic          push;
  logic          full;
  logic          accept;

  always_comb begin
    full   = (cnt == FULL);
    accept = (bound == 8'd0) || (bus.rnd_in < bound);
    // WAIT ignores rd_req but is always trying to serve its pending read
    serve  = ((state == IDLE) && bus.rd_req) || (state == WAIT);
    pop    = serve && (cnt != '0);
    push   = !bus.bound_we && !fault_r && !full && accept;
    if (!prev_valid)
      rep_next = '0;
    else if (bus.rnd_in == prev)
      rep_next = (rep == LIMIT) ? rep : rep + 8'd1;
    else
      rep_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr] <= bus.rnd_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      bound      <= '0;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      data_r     <= '0;
      fault_r    <= 1'b0;
      prev       <= '0;
      prev_valid <= 1'b0;
      rep        <= '0;
    end else begin
      ack_r  <= 1'b0;
      err_r  <= 1'b0;
      data_r <= '0;

      if (serve) begin
        if (pop) begin
          ack_r  <= 1'b1;
          data_r <= mem[rd_ptr];
          state  <= IDLE;
        end else if (fault_r) begin
          ack_r <= 1'b1;
          err_r <= 1'b1;
          state <= IDLE;
        end else begin
          state <= WAIT;
        end
      end

      // a bound change invalidates everything sampled under the old bound
      if (bus.bound_we) begin
        bound  <= bus.bound_in;
        cnt    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        cnt <= cnt + CW'(push) - CW'(pop);
      end

      prev       <= bus.rnd_in;
      prev_valid <= 1'b1;
      rep        <= rep_next;
      if (rep_next == LIMIT)
        fault_r <= 1'b1;
    end
  end

  assign bus.rd_ack  = ack_r;
  assign bus.rd_err  = err_r;
  assign bus.rd_data = data_r;
  assign bus.count   = cnt;
  assign bus.fault   = fault_r;
endmodule

// File: tb/tb_rnd_reader.sv
// Directed plus randomized bench for rnd_reader against a queue-based reference model.
module tb_rnd_reader;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rnd_reader_if #(.DEPTH(DEPTH)) bus ();

  rnd_reader #(.DEPTH(DEPTH), .STUCK_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0] mq[$];
  logic [7:0] m_bound = 0;
  logic [7:0] m_prev = 0;
  bit         m_pv = 0;
  int         m_rep = 0;
  bit         m_fault = 0;
  bit         m_wait = 0;
  bit         m_ack = 0;
  bit         m_err = 0;
  logic [7:0] m_data = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic [7:0] rnd, input logic we,
                       input logic [7:0] bnd, input logic req);
    int sz;
    bit full;
    m_ack = 0; m_err = 0; m_data = 0;
    if (r) begin
      mq.delete();
      m_bound = 0; m_fault = 0; m_pv = 0; m_rep = 0; m_wait = 0; m_prev = 0;
    end else begin
      sz = mq.size();
      full = (sz == DEPTH);
      if (m_wait || req) begin
        if (sz > 0) begin
          m_data = mq.pop_front(); m_ack = 1; m_wait = 0;
        end else if (m_fault) begin
          m_ack = 1; m_err = 1; m_wait = 0;
        end else begin
          m_wait = 1;
        end
      end
      if (we) begin
        mq.delete();
        m_bound = bnd;
      end else if (!m_fault && !full && (m_bound == 0 || rnd < m_bound)) begin
        mq.push_back(rnd);
      end
      if (!m_pv) begin
        m_pv = 1; m_rep = 0;
      end else if (rnd == m_prev) begin
        if (m_rep < LIMIT) m_rep++;
      end else begin
        m_rep = 0;
      end
      m_prev = rnd;
      if (m_rep == LIMIT) m_fault = 1;
    end
  endtask

  task automatic step(input logic r, input logic [7:0] rnd, input logic we,
                      input logic [7:0] bnd, input logic req);
    @(negedge clk);
    rst = r;
    bus.rnd_in = rnd;
    bus.bound_we = we;
    bus.bound_in = bnd;
    bus.rd_req = req;
    @(posedge clk);
    model(r, rnd, we, bnd, req);
    #1;
    chk("count", 32'(bus.count), mq.size());
    chk("rd_ack", 32'(bus.rd_ack), 32'(m_ack));
    chk("rd_err", 32'(bus.rd_err), 32'(m_err));
    chk("rd_data", 32'(bus.rd_data), 32'(m_data));
    chk("fault", 32'(bus.fault), 32'(m_fault));
  endtask

  function automatic logic [7:0] rb();
    return 8'($urandom);
  endfunction

  initial begin
    logic [7:0] fill_v[4];
    logic [7:0] seq[$];
    logic [7:0] v;
    fill_v[0] = 8'h11; fill_v[1] = 8'h22; fill_v[2] = 8'h33; fill_v[3] = 8'h44;
    bus.rnd_in = 0; bus.bound_we = 0; bus.bound_in = 0; bus.rd_req = 0;

    // reset
    step(1, 8'h00, 0, 0, 0);
    step(1, 8'h01, 0, 0, 0);
    chk("reset_count", 32'(bus.count), 0);
    chk("reset_fault", 32'(bus.fault), 0);

    // fill: fifth byte dropped by full FIFO
    step(0, 8'h11, 0, 0, 0);
    step(0, 8'h22, 0, 0, 0);
    step(0, 8'h33, 0, 0, 0);
    step(0, 8'h44, 0, 0, 0);
    step(0, 8'h55, 0, 0, 0);
    chk("fill_count", 32'(bus.count), 4);
    for (int i = 0; i < 4; i++) begin
      step(0, rb(), 0, 0, 1);
      chk("fill_ack", 32'(bus.rd_ack), 1);
      chk("fill_data", 32'(bus.rd_data), 32'(fill_v[i]));
      step(0, rb(), 0, 0, 0);
      chk("fill_ack_drop", 32'(bus.rd_ack), 0);
    end

    // rejection against bound 0x10, with a flush of a non-empty FIFO
    chk("rej_pre_nonempty", 32'(bus.count != 0), 1);
    step(0, 8'h01, 1, 8'h10, 0);
    chk("rej_flush", 32'(bus.count), 0);
    step(0, 8'h05, 0, 0, 0);
    step(0, 8'h10, 0, 0, 0);
    step(0, 8'hFF, 0, 0, 0);
    step(0, 8'h0F, 0, 0, 0);
    chk("rej_count", 32'(bus.count), 2);
    step(0, 8'h80, 0, 0, 1);
    chk("rej_data0", 32'(bus.rd_data), 8'h05);
    step(0, 8'h81, 0, 0, 1);
    chk("rej_data1", 32'(bus.rd_data), 8'h0F);

    // read from empty: request at t, 0x3C pushed at t+3, ack after t+4
    step(0, 8'h82, 1, 8'h40, 0);
    step(0, 8'h83, 0, 0, 1);
    chk("wait_ack_t", 32'(bus.rd_ack), 0);
    step(0, 8'h90, 0, 0, 1);
    chk("wait_ack_t1", 32'(bus.rd_ack), 0);
    step(0, 8'hA0, 0, 0, 0);
    chk("wait_ack_t2", 32'(bus.rd_ack), 0);
    step(0, 8'h3C, 0, 0, 0);
    chk("wait_ack_t3", 32'(bus.rd_ack), 0);
    chk("wait_count_t3", 32'(bus.count), 1);
    step(0, 8'hB0, 0, 0, 0);
    chk("wait_ack_t4", 32'(bus.rd_ack), 1);
    chk("wait_data_t4", 32'(bus.rd_data), 8'h3C);
    step(0, 8'hC1, 0, 0, 0);
    chk("wait_no_second_ack", 32'(bus.rd_ack), 0);
    step(0, 8'hD2, 0, 0, 0);
    chk("wait_no_second_ack2", 32'(bus.rd_ack), 0);

    // simultaneous push/pop at count=2 across pointer wrap
    step(0, 8'hE3, 1, 8'h00, 0);
    v = rb(); seq.push_back(v); step(0, v, 0, 0, 0);
    v = rb(); seq.push_back(v); step(0, v, 0, 0, 0);
    chk("pp_count_start", 32'(bus.count), 2);
    for (int i = 0; i < 10; i++) begin
      v = rb(); seq.push_back(v);
      step(0, v, 0, 0, 1);
      chk("pp_count", 32'(bus.count), 2);
      chk("pp_data", 32'(bus.rd_data), 32'(seq.pop_front()));
    end

    // stuck source
    step(1, 8'h00, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      step(0, 8'hAA, 0, 0, 0);
      chk("stuck_fault", 32'(bus.fault), 32'(k == 9));
    end
    chk("stuck_count", 32'(bus.count), 4);
    step(0, 8'h12, 0, 0, 1);
    chk("stuck_read_data", 32'(bus.rd_data), 8'hAA);
    step(0, 8'h34, 0, 0, 0);
    chk("stuck_no_push", 32'(bus.count), 3);
    for (int i = 0; i < 3; i++) begin
      step(0, rb(), 0, 0, 1);
      chk("stuck_drain_ack", 32'(bus.rd_ack), 1);
      chk("stuck_drain_data", 32'(bus.rd_data), 8'hAA);
    end
    step(0, rb(), 0, 0, 1);
    chk("stuck_err_ack", 32'(bus.rd_ack), 1);
    chk("stuck_err", 32'(bus.rd_err), 1);
    chk("stuck_err_data", 32'(bus.rd_data), 0);
    step(0, rb(), 0, 0, 0);
    chk("stuck_sticky", 32'(bus.fault), 1);
    step(1, 8'h00, 0, 0, 0);
    chk("stuck_rst_clear", 32'(bus.fault), 0);

    // reset while waiting
    step(0, 8'h50, 1, 8'h01, 0);
    step(0, 8'h60, 0, 0, 1);
    step(0, 8'h70, 0, 0, 0);
    step(1, 8'h00, 0, 0, 0);
    chk("rstw_count", 32'(bus.count), 0);
    chk("rstw_ack", 32'(bus.rd_ack), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, rb(), 0, 0, 0);
      chk("rstw_no_ack", 32'(bus.rd_ack), 0);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic we;
      we = ($urandom_range(0, 39) == 0);
      step(0, rb(), we, ($urandom_range(0, 2) == 0) ? 8'h00 : rb(),
           ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
